// File: rtl/multiphase_ctrl_regs_if.sv
// Register bus between the PS7 GP master bridge and multiphase_ctrl_regs.
// One-cycle wr/rd strobes; rdata is valid the cycle after rd_en.
interface multiphase_ctrl_regs_if #(
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (
        output wr_en,
        output rd_en,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/multiphase_ctrl_regs.sv
// Control/status registers and byte-counted SPI sequencer (ADC + 3 PM DACs).
// Optional SPI_READBACK_EN: captures adc_miso into ADC_DATA during ADC frames.
module multiphase_ctrl_regs #(
    parameter int SPI_DIV = 4,
    parameter int ADDR_W  = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    multiphase_ctrl_regs_if.slave  bus,
    output logic [15:0]            cycle_time,
    output logic                   mc_start,
    output logic [2:0]             pm_sync,
    output logic [2:0][10:0]       pm_max_a,
    output logic [2:0][10:0]       pm_max_b,
    output logic [10:0]            galvo_h_len,
    output logic [10:0]            galvo_v_len,
    output logic [31:0]            galvo_man,
    output logic [6:0]             periph_rst,
    output logic                   fft_cap,
    output logic                   in_cap,
    output logic [3:0]             dbg_sel,
    output logic                   sclk_adc,
    output logic                   mosi_adc,
    output logic                   csn_adc,
    input  logic                   adc_miso,
    output logic                   sclk_pm0,
    output logic                   mosi_pm0,
    output logic                   csn_pm0,
    output logic                   sclk_pm1,
    output logic                   mosi_pm1,
    output logic                   csn_pm1,
    output logic                   sclk_pm2,
    output logic                   mosi_pm2,
    output logic                   csn_pm2
);

    localparam int CW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;

    localparam logic [ADDR_W-1:0] A_MC  = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_PM0 = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_PM1 = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_PM2 = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_GVC = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_GVM = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] A_RST = ADDR_W'(32'h40);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD
    } state_t;

    // Registers
    logic [31:0] r_mc;
    logic [31:0] r_pm [3];
    logic [31:0] r_gvc;
    logic [31:0] r_gvm;
    logic [31:0] r_rst;
    logic [3:0]  r_cs_go;
    logic [1:0]  r_cs_n [4];
    logic [31:0] r_data [4];
    logic        r_mc_start;
    logic        r_fft_cap;
    logic        r_in_cap;

    // SPI sequencer state; channel 0 = ADC, 1..3 = PM0..PM2 DACs
    state_t      r_state;
    state_t      w_nstate;
    logic [CW-1:0] r_cnt;
    logic [5:0]  r_bits;
    logic [31:0] r_shift;
    logic [1:0]  r_ch;

    logic [ADDR_W-1:0] w_word;
    logic [3:0]  w_wr_cs;
    logic [3:0]  w_wr_data;
    logic [3:0]  w_trig_req;
    logic        w_trig;
    logic [1:0]  w_trig_ch;
    logic [1:0]  w_nb;
    logic [31:0] w_ld_shift;
    logic [5:0]  w_ld_bits;
    logic        w_cnt_end;
    logic        w_shift;
    logic        w_sample;
    logic        w_bit_dec;
    logic        w_fin;
    logic        w_busy;
    logic        w_sclk;
    logic        w_mosi;
    logic [31:0] w_rd_val;
    logic        w_wr_mc;
    logic        w_wr_rst;
    logic        w_unused;

    assign w_word    = {bus.addr[ADDR_W-1:2], 2'b00};
    assign w_wr_mc   = bus.wr_en && (w_word == A_MC);
    assign w_wr_rst  = bus.wr_en && (w_word == A_RST);
    assign w_nb      = bus.wdata[1:0];
    assign w_cnt_end = (r_cnt == CW'(SPI_DIV - 1));
    assign w_busy    = (r_state != S_IDLE);
    assign w_sclk    = (r_state == S_HIGH);
    assign w_mosi    = w_busy & r_shift[31];

    // Per-channel CS/DATA decode and 0->1 trigger detection on CS[31]
    always_comb begin
        w_wr_cs    = '0;
        w_wr_data  = '0;
        w_trig_req = '0;
        w_trig_ch  = '0;
        for (int x = 0; x < 4; x++) begin
            w_wr_cs[x]    = bus.wr_en && (w_word == ADDR_W'(24 + 8 * x));
            w_wr_data[x]  = bus.wr_en && (w_word == ADDR_W'(28 + 8 * x));
            w_trig_req[x] = w_wr_cs[x] && bus.wdata[31] && !r_cs_go[x];
            if (w_trig_req[x]) begin
                w_trig_ch = 2'(x);
            end
        end
        w_trig = (r_state == S_IDLE) && (|w_trig_req);
    end

    // Left-align DATA[8*nbytes-1:0] so the frame always shifts out of bit 31
    assign w_ld_shift = r_data[w_trig_ch] << {~w_nb, 3'b000};
    assign w_ld_bits  = 6'({w_nb, 3'b000}) + 6'd8;

    // SPI state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    // SPI next-state and per-cycle control strobes
    always_comb begin
        w_nstate  = r_state;
        w_shift   = 1'b0;
        w_sample  = 1'b0;
        w_bit_dec = 1'b0;
        w_fin     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_nstate = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_end) begin
                    w_nstate = S_HIGH;
                    w_sample = 1'b1;
                end
            end
            S_HIGH: begin
                if (w_cnt_end) begin
                    w_nstate = S_LOW;
                    w_shift  = 1'b1;
                end
            end
            S_LOW: begin
                if (w_cnt_end) begin
                    if (r_bits == 6'd1) begin
                        w_nstate = S_HOLD;
                    end else begin
                        w_nstate  = S_HIGH;
                        w_sample  = 1'b1;
                        w_bit_dec = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_cnt_end) begin
                    w_nstate = S_IDLE;
                    w_fin    = 1'b1;
                end
            end
            default: begin
                w_nstate = S_IDLE;
            end
        endcase
    end

    // SPI datapath: phase counter, bit counter, shift register, channel
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_ch    <= '0;
        end else if (w_trig) begin
            r_cnt   <= '0;
            r_bits  <= w_ld_bits;
            r_shift <= w_ld_shift;
            r_ch    <= w_trig_ch;
        end else if (w_busy) begin
            if (w_cnt_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_shift) begin
                r_shift <= {r_shift[30:0], 1'b0};
            end
            if (w_bit_dec) begin
                r_bits <= r_bits - 6'd1;
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic [31:0] r_rx;

    // Capture adc_miso on every rising sclk of an ADC frame
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rx <= '0;
        end else if (w_trig) begin
            r_rx <= '0;
        end else if (w_sample && (r_ch == 2'd0)) begin
            r_rx <= {r_rx[30:0], adc_miso};
        end
    end
`endif

    // Register file writes and 0->1 pulse generation
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mc       <= '0;
            r_gvc      <= '0;
            r_gvm      <= '0;
            r_rst      <= '0;
            r_cs_go    <= '0;
            r_mc_start <= 1'b0;
            r_fft_cap  <= 1'b0;
            r_in_cap   <= 1'b0;
            for (int n = 0; n < 3; n++) begin
                r_pm[n] <= '0;
            end
            for (int x = 0; x < 4; x++) begin
                r_cs_n[x] <= '0;
                r_data[x] <= '0;
            end
        end else begin
            r_mc_start <= w_wr_mc && bus.wdata[31] && !r_mc[31];
            r_fft_cap  <= w_wr_rst && bus.wdata[7] && !r_rst[7];
            r_in_cap   <= w_wr_rst && bus.wdata[8] && !r_rst[8];
            if (bus.wr_en) begin
                case (w_word)
                    A_MC:    r_mc    <= bus.wdata;
                    A_PM0:   r_pm[0] <= bus.wdata;
                    A_PM1:   r_pm[1] <= bus.wdata;
                    A_PM2:   r_pm[2] <= bus.wdata;
                    A_GVC:   r_gvc   <= bus.wdata;
                    A_GVM:   r_gvm   <= bus.wdata;
                    A_RST:   r_rst   <= bus.wdata;
                    default: ;
                endcase
            end
            for (int x = 0; x < 4; x++) begin
                if (w_wr_cs[x]) begin
                    r_cs_go[x] <= bus.wdata[31];
                    r_cs_n[x]  <= bus.wdata[1:0];
                end
                if (w_wr_data[x]) begin
                    r_data[x] <= bus.wdata;
                end
            end
`ifdef SPI_READBACK_EN
            if (w_fin && (r_ch == 2'd0)) begin
                r_data[0] <= r_rx;
            end
`endif
        end
    end

    // Read mux; unmapped offsets return zero
    always_comb begin
        w_rd_val = '0;
        case (w_word)
            A_MC:    w_rd_val = r_mc;
            A_PM0:   w_rd_val = r_pm[0];
            A_PM1:   w_rd_val = r_pm[1];
            A_PM2:   w_rd_val = r_pm[2];
            A_GVC:   w_rd_val = r_gvc;
            A_GVM:   w_rd_val = r_gvm;
            A_RST:   w_rd_val = r_rst;
            default: w_rd_val = '0;
        endcase
        for (int x = 0; x < 4; x++) begin
            if (w_word == ADDR_W'(24 + 8 * x)) begin
                w_rd_val = {r_cs_go[x], w_busy && (r_ch == 2'(x)),
                            28'b0, r_cs_n[x]};
            end
            if (w_word == ADDR_W'(28 + 8 * x)) begin
                w_rd_val = r_data[x];
            end
        end
    end

    // Registered read data, sampled from pre-write register state
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.rdata <= '0;
        end else if (bus.rd_en) begin
            bus.rdata <= w_rd_val;
        end
    end

    assign cycle_time  = r_mc[15:0];
    assign mc_start    = r_mc_start;
    assign galvo_h_len = r_gvc[26:16];
    assign galvo_v_len = r_gvc[10:0];
    assign galvo_man   = r_gvm;
    assign periph_rst  = r_rst[6:0];
    assign fft_cap     = r_fft_cap;
    assign in_cap      = r_in_cap;
    assign dbg_sel     = r_rst[15:12];

    for (genvar n = 0; n < 3; n++) begin : g_pm
        assign pm_sync[n]  = r_pm[n][31];
        assign pm_max_a[n] = r_pm[n][26:16];
        assign pm_max_b[n] = r_pm[n][10:0];
    end

    assign csn_adc  = ~(w_busy && (r_ch == 2'd0));
    assign sclk_adc = w_sclk && (r_ch == 2'd0);
    assign mosi_adc = w_mosi && (r_ch == 2'd0);
    assign csn_pm0  = ~(w_busy && (r_ch == 2'd1));
    assign sclk_pm0 = w_sclk && (r_ch == 2'd1);
    assign mosi_pm0 = w_mosi && (r_ch == 2'd1);
    assign csn_pm1  = ~(w_busy && (r_ch == 2'd2));
    assign sclk_pm1 = w_sclk && (r_ch == 2'd2);
    assign mosi_pm1 = w_mosi && (r_ch == 2'd2);
    assign csn_pm2  = ~(w_busy && (r_ch == 2'd3));
    assign sclk_pm2 = w_sclk && (r_ch == 2'd3);
    assign mosi_pm2 = w_mosi && (r_ch == 2'd3);

    assign w_unused = ^{bus.addr[1:0], adc_miso, w_sample, w_fin};

endmodule

// File: tb/tb_multiphase_ctrl_regs.sv
// Directed self-checking bench for multiphase_ctrl_regs.
// ADC MISO is looped back from MOSI so ADC_DATA is identical with or without readback.
module tb_multiphase_ctrl_regs;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    multiphase_ctrl_regs_if #(.ADDR_W(8)) bus ();

    logic [15:0]      cycle_time;
    logic             mc_start;
    logic [2:0]       pm_sync;
    logic [2:0][10:0] pm_max_a;
    logic [2:0][10:0] pm_max_b;
    logic [10:0]      galvo_h_len;
    logic [10:0]      galvo_v_len;
    logic [31:0]      galvo_man;
    logic [6:0]       periph_rst;
    logic             fft_cap;
    logic             in_cap;
    logic [3:0]       dbg_sel;
    logic sclk_adc, mosi_adc, csn_adc, adc_miso;
    logic sclk_pm0, mosi_pm0, csn_pm0;
    logic sclk_pm1, mosi_pm1, csn_pm1;
    logic sclk_pm2, mosi_pm2, csn_pm2;

    assign adc_miso = mosi_adc;

    multiphase_ctrl_regs #(.SPI_DIV(4), .ADDR_W(8)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .bus         (bus),
        .cycle_time  (cycle_time),
        .mc_start    (mc_start),
        .pm_sync     (pm_sync),
        .pm_max_a    (pm_max_a),
        .pm_max_b    (pm_max_b),
        .galvo_h_len (galvo_h_len),
        .galvo_v_len (galvo_v_len),
        .galvo_man   (galvo_man),
        .periph_rst  (periph_rst),
        .fft_cap     (fft_cap),
        .in_cap      (in_cap),
        .dbg_sel     (dbg_sel),
        .sclk_adc    (sclk_adc),
        .mosi_adc    (mosi_adc),
        .csn_adc     (csn_adc),
        .adc_miso    (adc_miso),
        .sclk_pm0    (sclk_pm0),
        .mosi_pm0    (mosi_pm0),
        .csn_pm0     (csn_pm0),
        .sclk_pm1    (sclk_pm1),
        .mosi_pm1    (mosi_pm1),
        .csn_pm1     (csn_pm1),
        .sclk_pm2    (sclk_pm2),
        .mosi_pm2    (mosi_pm2),
        .csn_pm2     (csn_pm2)
    );

    int n_chk = 0;
    int n_err = 0;

    // Pulse counters, sampled mid-cycle
    int n_mc = 0;
    int n_fft = 0;
    int n_in = 0;
    always @(negedge aclk) begin
        if (mc_start === 1'b1) n_mc++;
        if (fft_cap === 1'b1) n_fft++;
        if (in_cap === 1'b1) n_in++;
    end

    // SPI monitors: rising sclk count, MSB-first bit capture, frame count
    int sck0 = 0, sck1 = 0, sck2 = 0, sck3 = 0;
    int frm0 = 0, frm1 = 0, frm2 = 0, frm3 = 0;
    logic [31:0] rx0 = '0, rx1 = '0, rx2 = '0, rx3 = '0;
    always @(posedge sclk_adc) begin sck0++; rx0 = {rx0[30:0], mosi_adc}; end
    always @(posedge sclk_pm0) begin sck1++; rx1 = {rx1[30:0], mosi_pm0}; end
    always @(posedge sclk_pm1) begin sck2++; rx2 = {rx2[30:0], mosi_pm1}; end
    always @(posedge sclk_pm2) begin sck3++; rx3 = {rx3[30:0], mosi_pm2}; end
    always @(negedge csn_adc) frm0++;
    always @(negedge csn_pm0) frm1++;
    always @(negedge csn_pm1) frm2++;
    always @(negedge csn_pm2) frm3++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge aclk);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge aclk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge aclk);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        @(negedge aclk);
        bus.rd_en = 1'b0;
        d = bus.rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic wait_csn(input int ch, output int t);
        t = 0;
        while (t < 2000) begin
            if ((ch == 0 && csn_adc === 1'b1) || (ch == 1 && csn_pm0 === 1'b1) ||
                (ch == 2 && csn_pm1 === 1'b1) || (ch == 3 && csn_pm2 === 1'b1))
                break;
            @(negedge aclk);
            t++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int t;
        int b_s0, b_s1, b_s2, b_s3, b_f0, b_f1, b_f2, b_f3;

        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        idle(3);

        chk("rst_csn", {28'b0, csn_adc, csn_pm0, csn_pm1, csn_pm2}, 32'hF);
        chk("rst_sclk", {28'b0, sclk_adc, sclk_pm0, sclk_pm1, sclk_pm2}, 32'h0);
        chk("rst_mosi", {28'b0, mosi_adc, mosi_pm0, mosi_pm1, mosi_pm2}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_pulses", {29'b0, mc_start, fft_cap, in_cap}, 32'h0);
        chk("rst_periph", {25'b0, periph_rst}, 32'h0);

        @(negedge aclk);
        aresetn = 1'b1;
        idle(2);

        // Master control
        wr(8'h00, 32'h0000_8BB8);
        chk("cycle_time", {16'b0, cycle_time}, 32'd35768);
        chk("mc_no_pulse", n_mc, 0);
        wr(8'h00, 32'h0);
        wr(8'h00, 32'h8000_0000);
        chk("mc_start_hi", {31'b0, mc_start}, 32'h1);
        wr(8'h00, 32'h8000_0000);
        chk("mc_start_lo", {31'b0, mc_start}, 32'h0);
        wr(8'h00, 32'h0);
        chk("mc_pulse_cnt", n_mc, 1);

        // Reset/debug register
        wr(8'h40, 32'h0);
        wr(8'h40, 32'h7F);
        chk("periph_on", {25'b0, periph_rst}, 32'h7F);
        wr(8'h40, 32'h0);
        chk("periph_off", {25'b0, periph_rst}, 32'h0);
        wr(8'h40, 32'h1100);
        chk("in_cap_hi", {31'b0, in_cap}, 32'h1);
        chk("dbg_sel", {28'b0, dbg_sel}, 32'h1);
        wr(8'h40, 32'h80);
        chk("fft_cap_hi", {31'b0, fft_cap}, 32'h1);
        idle(3);
        chk("in_cap_cnt", n_in, 1);
        chk("fft_cap_cnt", n_fft, 1);
        rd(8'h40, d);
        chk("rst_dbg_rd", d, 32'h80);

        // Phase modulators
        wr(8'h04, 32'h801E_0010);
        chk("pm0_sync_hi", {29'b0, pm_sync}, 32'h1);
        chk("pm0_max_a", {21'b0, pm_max_a[0]}, 32'h01E);
        chk("pm0_max_b", {21'b0, pm_max_b[0]}, 32'h010);
        rd(8'h04, d);
        chk("pm0_rd", d, 32'h801E_0010);
        wr(8'h04, 32'h001E_0010);
        chk("pm0_sync_lo", {29'b0, pm_sync}, 32'h0);
        wr(8'h0C, 32'h8005_0006);
        chk("pm2_sync", {29'b0, pm_sync}, 32'h4);
        chk("pm2_max_a", {21'b0, pm_max_a[2]}, 32'h005);
        chk("pm2_max_b", {21'b0, pm_max_b[2]}, 32'h006);

        // Galvo
        wr(8'h10, 32'h07FF_0123);
        chk("galvo_h", {21'b0, galvo_h_len}, 32'h7FF);
        chk("galvo_v", {21'b0, galvo_v_len}, 32'h123);
        wr(8'h14, 32'hDEAD_BEEF);
        chk("galvo_man", galvo_man, 32'hDEAD_BEEF);

        // Write and read of the same address in one cycle
        @(negedge aclk);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.addr  = 8'h14;
        bus.wdata = 32'h1234_5678;
        @(negedge aclk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk("rdwr_old", bus.rdata, 32'hDEAD_BEEF);
        chk("rdwr_new", galvo_man, 32'h1234_5678);

        // Unmapped offset
        wr(8'h3C, 32'hFFFF_FFFF);
        rd(8'h3C, d);
        chk("unmapped_rd", d, 32'h0);

        // DAC0: 3-byte frame, DATA rewritten mid-frame
        b_s0 = sck0; b_s1 = sck1; b_s2 = sck2; b_s3 = sck3;
        b_f0 = frm0; b_f1 = frm1; b_f2 = frm2; b_f3 = frm3;
        wr(8'h24, 32'h0003_1450);
        wr(8'h20, 32'h2);
        wr(8'h20, 32'h8000_0002);
        chk("dac0_csn_lo", {31'b0, csn_pm0}, 32'h0);
        rd(8'h20, d);
        chk("dac0_cs_busy", d, 32'hC000_0002);
        wr(8'h24, 32'h00AB_CDEF);
        wait_csn(1, t);
        chk("dac0_timeout", {31'b0, t < 2000}, 32'h1);
        chk("dac0_sclks", sck1 - b_s1, 24);
        chk("dac0_bits", rx1 & 32'h00FF_FFFF, 32'h0003_1450);
        chk("dac0_frames", frm1 - b_f1, 1);
        chk("dac0_others",
            (sck0 - b_s0) + (sck2 - b_s2) + (sck3 - b_s3) +
            (frm0 - b_f0) + (frm2 - b_f2) + (frm3 - b_f3), 0);
        rd(8'h20, d);
        chk("dac0_cs_idle", d, 32'h8000_0002);
        rd(8'h24, d);
        chk("dac0_data_rd", d, 32'h00AB_CDEF);
        chk("dac0_mosi_idle", {31'b0, mosi_pm0}, 32'h0);
        wr(8'h20, 32'h2);

        // ADC: 4-byte frame, retrigger while busy ignored
        b_s0 = sck0; b_f0 = frm0;
        wr(8'h1C, 32'hA5C3_0F96);
        wr(8'h18, 32'h3);
        wr(8'h18, 32'h8000_0003);
        idle(10);
        wr(8'h18, 32'h3);
        wr(8'h18, 32'h8000_0003);
        rd(8'h18, d);
        chk("adc_cs_busy", d, 32'hC000_0003);
        wait_csn(0, t);
        chk("adc_timeout", {31'b0, t < 2000}, 32'h1);
        chk("adc_sclks", sck0 - b_s0, 32);
        chk("adc_bits", rx0, 32'hA5C3_0F96);
        idle(300);
        chk("adc_frames", frm0 - b_f0, 1);
        rd(8'h18, d);
        chk("adc_cs_idle", d, 32'h8000_0003);
        rd(8'h1C, d);
        chk("adc_data_rd", d, 32'hA5C3_0F96);

        // Reset in the middle of a DAC1 frame
        wr(8'h00, 32'h0000_8BB8);
        wr(8'h2C, 32'h0000_00FF);
        wr(8'h28, 32'h0);
        wr(8'h28, 32'h8000_0000);
        idle(20);
        chk("dac1_active", {31'b0, csn_pm1}, 32'h0);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("abort_csn", {28'b0, csn_adc, csn_pm0, csn_pm1, csn_pm2}, 32'hF);
        chk("abort_sclk_mosi", {30'b0, sclk_pm1, mosi_pm1}, 32'h0);
        chk("abort_cycle", {16'b0, cycle_time}, 32'h0);
        chk("abort_galvo", galvo_man, 32'h0);
        chk("abort_pm", {29'b0, pm_sync}, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        rd(8'h28, d);
        chk("abort_cs1", d, 32'h0);
        rd(8'h2C, d);
        chk("abort_data1", d, 32'h0);
        rd(8'h0C, d);
        chk("abort_pm2_rd", d, 32'h0);
        rd(8'h00, d);
        chk("abort_mc_rd", d, 32'h0);
        rd(8'h3C, d);
        chk("abort_unmapped", d, 32'h0);
        idle(100);
        chk("abort_no_resume", {31'b0, csn_pm1}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
